rr_arbiter_4: RTL
=================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles to one requester while others wait; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 req  input  4  request vector; bit i = requester i wants the shared resource.
REQ-005 gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-006 gnt_id  output  2  binary index of granted requester; 2'b00 when idle.
REQ-007 gnt_valid  output  1  high exactly when gnt is non-zero.

Function
REQ-008 The block SHALL keep a 2-bit priority pointer ptr; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4); first requesting index in that order is "sel".
REQ-009 The block SHALL implement FSM states IDLE and GRANT, with all outputs registered.
REQ-010 IDLE, req==0: stay IDLE, outputs zero.
REQ-011 IDLE, req!=0: next edge enter GRANT with gnt=onehot(sel), gnt_id=sel, hold_cnt=0, ptr=sel+1; latency is one clock from req to gnt.
REQ-012 GRANT, req[gnt_id]==0 and other requests present: next edge grant sel (searched from ptr) with no idle cycle, hold_cnt=0, ptr=sel+1.
REQ-013 GRANT, req==0: next edge return to IDLE, outputs zero; ptr unchanged.
REQ-014 GRANT, req[gnt_id]==1, hold_cnt==MAX_HOLD-1 and (req & ~gnt)!=0: next edge preempt to sel chosen among other requesters, hold_cnt=0, ptr=sel+1.
REQ-015 GRANT, req[gnt_id]==1, otherwise: keep grant; hold_cnt increments, saturating at MAX_HOLD-1 (sole requester is never preempted).
REQ-016 gnt SHALL never have more than one bit set; gnt_id SHALL always equal the encoded gnt.
REQ-017 Requests arriving or dropping in the same cycle as a release or preemption SHALL be evaluated on the req value sampled at that edge only.
REQ-018 ptr wrap-around SHALL be modulo 4 (3+1 -> 0).
REQ-019 hold_cnt width SHALL be 8 bits.

Reset
REQ-020 rst_n low SHALL immediately force state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, ptr=2'b00, hold_cnt=0, regardless of clk.
REQ-021 Reset asserted mid-grant SHALL drop the grant at once; first edge after deassertion SHALL arbitrate from ptr=0.

Structure
REQ-022 FSM state encodings (IDLE=1'b0, GRANT=1'b1) and default MAX_HOLD SHALL live in a shared include arb_defs.vh.
REQ-023 Rotated-request selection SHALL use one sub-module prio_encoder_4_2 (4-bit in, 2-bit index out, valid out, bit 0 highest priority); rr_arbiter_4 rotates req by ptr before it and adds ptr back after.
REQ-024 No other sub-modules; single always block for sequential state, combinational next-state logic separate.

Verification (MAX_HOLD=4)
REQ-025 rst_n=0 with req=4'b1111 -> gnt=0000, gnt_valid=0; first edge after release -> gnt=0001, gnt_id=00.
REQ-026 req=4'b1111 held -> gnt 0001 x4 cycles, 0010 x4, 0100 x4, 1000 x4, then 0001 again.
REQ-027 req=4'b0100 held 20 cycles -> gnt=0100 throughout, no preemption, gnt_id=10.
REQ-028 req=4'b0011, gnt=0001; drop req[0] -> next edge gnt=0010 (no gap); then req=0000 -> next edge gnt=0000, gnt_valid=0.
REQ-029 Async reset pulse between edges while gnt=0100 -> gnt=0000 immediately; after release req=4'b1100 -> gnt=0100 (ptr=0 search).
REQ-030 Every cycle of all runs: gnt one-hot or zero, gnt_id matches gnt, gnt_valid==|gnt.

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// Package for the 4-way round-robin arbiter.
// Provides FSM state constants, the default MAX_HOLD value and small helpers
// for one-hot encoding and request rotation. No ports.
`include "arb_defs.vh"

package rr_arbiter_4_pkg;

    localparam logic [0:0] ST_IDLE          = `ARB_ST_IDLE;
    localparam logic [0:0] ST_GRANT         = `ARB_ST_GRANT;
    localparam int         MAX_HOLD_DEFAULT = `ARB_MAX_HOLD_DEFAULT;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Rotate right so that bit 'sh' of v lands at bit 0: result[k] = v[(sh+k) mod 4].
    function automatic logic [3:0] rotr4(input logic [3:0] v, input logic [1:0] sh);
        logic [7:0] dbl;
        dbl = {v, v} >> sh;
        return dbl[3:0];
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle of the 4-way round-robin arbiter.
//   req       : request vector, bit i = requester i wants the resource
//   gnt       : one-hot grant (zero when idle)
//   gnt_id    : binary index of the granted requester (0 when idle)
//   gnt_valid : high exactly when gnt is non-zero
// master = requester side, slave = arbiter side.
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    modport master (output req, input gnt, input gnt_id, input gnt_valid);
    modport slave  (input req, output gnt, output gnt_id, output gnt_valid);
endinterface

// File: rtl/arb_defs.vh
// Shared arbiter definitions: FSM state encodings and the default hold limit.
// Included by the arbiter package so every file sees one set of values.
`ifndef ARB_DEFS_VH
`define ARB_DEFS_VH

`define ARB_ST_IDLE          1'b0
`define ARB_ST_GRANT         1'b1
`define ARB_MAX_HOLD_DEFAULT 8

`endif

// File: rtl/rr_arbiter_4_prio_encoder.sv
// Fixed-priority encoder, 4 inputs to 2-bit index, bit 0 highest priority.
//   req_i   : input vector
//   idx_o   : index of lowest set bit (0 when none set)
//   valid_o : high when any input bit is set
module prio_encoder_4_2 (
    input  logic [3:0] req_i,
    output logic [1:0] idx_o,
    output logic       valid_o
);
    always_comb begin
        valid_o = |req_i;
        idx_o   = 2'd0;
        if (req_i[0])      idx_o = 2'd0;
        else if (req_i[1]) idx_o = 2'd1;
        else if (req_i[2]) idx_o = 2'd2;
        else if (req_i[3]) idx_o = 2'd3;
    end
endmodule

// File: rtl/rr_arbiter_4.sv
// 4-way round-robin arbiter with bounded hold time.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : rr_arbiter_4_if.slave (req in; gnt, gnt_id, gnt_valid out, all registered)
// A requester keeps the grant while it requests, but after MAX_HOLD cycles it is
// preempted if anybody else is waiting. A sole requester is never preempted.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter_4_if.slave  bus
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;

    logic       holder_req;
    logic       others_req;
    logic       preempt;
    logic [3:0] cand;
    logic [3:0] cand_rot;
    logic [1:0] enc_idx;
    logic       enc_valid;
    logic [1:0] sel;

    assign holder_req = bus.req[gnt_id_q];
    assign others_req = |(bus.req & ~gnt_q);
    assign preempt    = (state_q == ST_GRANT) && holder_req &&
                        (hold_q == HOLD_LAST) && others_req;

    // On preemption the current holder is masked out so the search lands on
    // someone else; in every other case the raw request vector is searched.
    assign cand     = preempt ? (bus.req & ~gnt_q) : bus.req;
    assign cand_rot = rotr4(cand, ptr_q);

    prio_encoder_4_2 u_prio (
        .req_i   (cand_rot),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    // Undo the rotation; 2-bit addition wraps modulo 4.
    assign sel = ptr_q + enc_idx;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_d     = ST_GRANT;
                    gnt_d       = onehot4(sel);
                    gnt_id_d    = sel;
                    gnt_valid_d = 1'b1;
                    ptr_d       = sel + 2'd1;
                    hold_d      = 8'd0;
                end
            end
            default: begin
                if (!enc_valid) begin
                    // Nobody requesting: release, pointer stays where it is.
                    state_d     = ST_IDLE;
                    gnt_d       = 4'b0000;
                    gnt_id_d    = 2'd0;
                    gnt_valid_d = 1'b0;
                    hold_d      = 8'd0;
                end else if (!holder_req || preempt) begin
                    // Hand over without an idle cycle.
                    gnt_d       = onehot4(sel);
                    gnt_id_d    = sel;
                    gnt_valid_d = 1'b1;
                    ptr_d       = sel + 2'd1;
                    hold_d      = 8'd0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= 2'd0;
            hold_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule
